apb_uart: RTL and testbench

- APB-slave-programmable UART with a single transmit holding register, a single receive holding register and RTS/CTS hardware flow control.
- Configurable frame: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits.
- Baud rate is set by a programmable 16x-oversampling divisor.
- Sits on the peripheral APB bus and drives the external tx/rts_n pins.

---
 rtl/apb_uart.sv | 275 +++++++++++++++++++++++++++
 tb/tb_apb_uart.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart.sv
// APB-programmable UART: one TX and one RX holding register, 5-8 data bits,
// optional parity, 1/2 stop bits, 16x oversampling, RTS/CTS flow control.
module apb_uart #(
    parameter int          ADDR_W   = 12,
    parameter logic [15:0] BAUD_RST = 16'd26
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        pstrb,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       prdata,
    input  logic              rx,
    input  logic              cts_n,
    output logic              tx,
    output logic              rts_n
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic       acc, addr_ok, wr_ok, rd_rx;
    logic [2:0] reg_idx;
    logic [2:0] w1c;

    logic [7:0]  tx_data;
    logic [4:0]  cfg;
    logic        cts_en;
    logic        start_tx;
    logic [15:0] baud;
    logic        tx_busy;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic [7:0]  rx_data;

    assign pready  = 1'b1;
    assign acc     = psel & penable;
    assign reg_idx = paddr[4:2];
    assign addr_ok = ((paddr >> 5) == '0) && (paddr[1:0] == 2'b00) && (reg_idx <= 3'd5);
    assign wr_ok   = acc & pwrite & addr_ok & (reg_idx != 3'd1);
    assign rd_rx   = acc & ~pwrite & addr_ok & (reg_idx == 3'd1);
    assign pslverr = acc & (~addr_ok | (pwrite & (reg_idx == 3'd1)));
    assign w1c     = (wr_ok && pstrb[0] && reg_idx == 3'd4) ? pwdata[4:2] : 3'b000;

    logic unused_ok;
    assign unused_ok = ^{pwdata[31:16], pstrb[3:2]};

    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

    // Even parity is the XOR of the used data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [7:0] d, input logic [4:0] c);
        return (^(d & data_mask(c[1:0]))) ^ ~c[4];
    endfunction

    always_comb begin
        prdata = '0;
        if (acc && addr_ok) begin
            case (reg_idx)
                3'd0:    prdata[7:0]  = tx_data;
                3'd1:    prdata[7:0]  = rx_data;
                3'd2:    prdata[4:0]  = cfg;
                3'd3:    prdata[1:0]  = {cts_en, start_tx};
                3'd4:    prdata[4:0]  = {overrun, frame_err, parity_err, rx_valid, tx_busy};
                3'd5:    prdata[15:0] = baud;
                default: prdata       = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_data  <= '0;
            cfg      <= 5'h03;
            cts_en   <= 1'b0;
            start_tx <= 1'b0;
            baud     <= BAUD_RST;
        end else begin
            start_tx <= 1'b0;
            if (wr_ok && pstrb[0]) begin
                case (reg_idx)
                    3'd0:    tx_data <= pwdata[7:0];
                    3'd2:    cfg     <= pwdata[4:0];
                    3'd3:    begin
                        start_tx <= pwdata[0];
                        cts_en   <= pwdata[1];
                    end
                    3'd5:    baud[7:0] <= pwdata[7:0];
                    default: ;
                endcase
            end
            if (wr_ok && pstrb[1] && reg_idx == 3'd5)
                baud[15:8] <= pwdata[15:8];
        end
    end

    // Transmitter: divisor tracks BAUD while idle and freezes for the frame.
    state_t      tx_state;
    logic [15:0] tx_pre, tx_div;
    logic        tx_tick, tx_bit_end;
    logic [3:0]  tx_tcnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic [4:0]  tx_cfg;
    logic        tx_par, tx_stop2;
    logic [1:0]  cts_sync;

    assign tx_tick    = (tx_pre >= tx_div);
    assign tx_bit_end = tx_tick && (tx_tcnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_pre   <= '0;
            tx_div   <= BAUD_RST;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_cfg   <= '0;
            tx_par   <= 1'b0;
            tx_stop2 <= 1'b0;
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
            tx_pre   <= tx_tick ? '0 : tx_pre + 16'd1;
            if (!tx_busy)
                tx_div <= baud;
            if (tx_tick)
                tx_tcnt <= tx_tcnt + 4'd1;
            case (tx_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!tx_busy) begin
                        if (start_tx) begin
                            tx_busy  <= 1'b1;
                            tx_shift <= tx_data & data_mask(cfg[1:0]);
                            tx_par   <= calc_parity(tx_data, cfg);
                            tx_cfg   <= cfg;
                        end
                    end else if (tx_tick && !(cts_en && cts_sync[1])) begin
                        tx_state <= START;
                        tx       <= 1'b0;
                        tx_tcnt  <= '0;
                    end
                end
                START: if (tx_bit_end) begin
                    tx_state <= DATA;
                    tx       <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= '0;
                end
                DATA: if (tx_bit_end) begin
                    if (tx_bit == {1'b1, tx_cfg[1:0]}) begin
                        tx_state <= tx_cfg[3] ? PARITY : STOP;
                        tx       <= tx_cfg[3] ? tx_par : 1'b1;
                        tx_stop2 <= 1'b0;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                PARITY: if (tx_bit_end) begin
                    tx_state <= STOP;
                    tx       <= 1'b1;
                    tx_stop2 <= 1'b0;
                end
                STOP: if (tx_bit_end) begin
                    if (tx_cfg[2] && !tx_stop2) begin
                        tx_stop2 <= 1'b1;
                    end else begin
                        tx_state <= IDLE;
                        tx_busy  <= 1'b0;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Receiver: prescaler restarts on the start edge so tick 8 lands mid-bit.
    state_t      rx_state;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_fall;
    logic [15:0] rx_pre, rx_div;
    logic        rx_tick, rx_bit_end, rx_done, rx_par_bad;
    logic [3:0]  rx_tcnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_byte;
    logic [4:0]  rx_cfg;
    logic        rx_par_bit;

    assign rx_s       = rx_sync[1];
    assign rx_fall    = rx_prev & ~rx_s;
    assign rx_tick    = (rx_pre >= rx_div);
    assign rx_bit_end = rx_tick && (rx_tcnt == 4'd15);
    assign rx_byte    = rx_shift >> (2'd3 - rx_cfg[1:0]);
    assign rx_done    = (rx_state == STOP) && rx_bit_end;
    assign rx_par_bad = rx_cfg[3] && (rx_par_bit != calc_parity(rx_byte, rx_cfg));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state   <= IDLE;
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_pre     <= '0;
            rx_div     <= BAUD_RST;
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_cfg     <= '0;
            rx_par_bit <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            rts_n      <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            rx_pre  <= rx_tick ? '0 : rx_pre + 16'd1;
            if (rx_tick)
                rx_tcnt <= rx_tcnt + 4'd1;
            case (rx_state)
                IDLE: if (rx_fall) begin
                    rx_state <= START;
                    rx_pre   <= '0;
                    rx_tcnt  <= '0;
                    rx_div   <= baud;
                    rx_cfg   <= cfg;
                end
                START: if (rx_tick && rx_tcnt == 4'd7) begin
                    rx_state <= rx_s ? IDLE : DATA;
                    rx_tcnt  <= '0;
                    rx_bit   <= '0;
                end
                DATA: if (rx_bit_end) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    if (rx_bit == {1'b1, rx_cfg[1:0]})
                        rx_state <= rx_cfg[3] ? PARITY : STOP;
                    else
                        rx_bit <= rx_bit + 3'd1;
                end
                PARITY: if (rx_bit_end) begin
                    rx_par_bit <= rx_s;
                    rx_state   <= STOP;
                end
                STOP: if (rx_bit_end)
                    rx_state <= IDLE;
                default: rx_state <= IDLE;
            endcase

            // A read in the completion cycle frees the slot for the new byte.
            if (rx_done && (!rx_valid || rd_rx)) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            parity_err <= (parity_err & ~w1c[0]) | (rx_done & rx_par_bad);
            frame_err  <= (frame_err & ~w1c[1]) | (rx_done & ~rx_s);
            overrun    <= (overrun & ~w1c[2]) | (rx_done & rx_valid & ~rd_rx);
            rts_n      <= rx_valid;
        end
    end
endmodule

// File: tb/tb_apb_uart.sv
// Randomized bench for apb_uart: a frame-level TX model checked every cycle,
// an RX status model updated per sent frame, plus literal directed checks.
module tb_apb_uart;
    logic        clk = 1'b0;
    logic        reset_n, psel, penable, pwrite;
    logic [3:0]  pstrb;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        rx, cts_n, tx, rts_n;

    always #5 clk = ~clk;

    apb_uart #(.ADDR_W(12), .BAUD_RST(16'd26)) dut (
        .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .rx(rx), .cts_n(cts_n), .tx(tx), .rts_n(rts_n)
    );

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Expected TX frames, bit 0 = start bit, each bit lasting len clocks.
    typedef struct { logic [11:0] bits; int n; int len; } frame_t;
    frame_t txq[$];
    frame_t cur;
    bit     mon_on = 0, in_frame = 0;
    int     fcyc;

    function automatic frame_t make_frame(input logic [7:0] d, input logic [4:0] c, input int div);
        frame_t f;
        int nb, k, ones;
        nb = 5 + int'(c[1:0]);
        ones = 0;
        f.bits = '0;
        for (int i = 0; i < nb; i++) begin
            f.bits[1+i] = d[i];
            ones += int'(d[i]);
        end
        k = 1 + nb;
        if (c[3]) begin
            f.bits[k] = c[4] ? (ones % 2 == 1) : (ones % 2 == 0);
            k++;
        end
        f.bits[k] = 1'b1; k++;
        if (c[2]) begin f.bits[k] = 1'b1; k++; end
        f.n = k;
        f.len = 16 * (div + 1);
        return f;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (!in_frame && tx === 1'b0 && txq.size() > 0) begin
                cur = txq.pop_front();
                in_frame = 1;
                fcyc = 0;
            end
            if (in_frame) begin
                chk("tx_bit", tx, cur.bits[fcyc / cur.len]);
                fcyc++;
                if (fcyc == cur.n * cur.len) in_frame = 0;
            end else begin
                chk("tx_idle", tx, 1);
            end
        end
    end

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output logic err);
        @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk); penable = 1; #1 err = pslverr;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, 4'hF, e);
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clk); penable = 1; #1 d = prdata; err = pslverr;
        @(negedge clk); psel = 0; penable = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        logic e;
        apb_rd(a, d, e);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] d;
        int n;
        n = 0;
        rd(12'h010, d);
        while (d[0] && n < 20000) begin
            rd(12'h010, d);
            n++;
        end
        chk(name, d[0], 0);
    endtask

    task automatic drive_bit(input logic b, input int len);
        @(negedge clk); rx = b;
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic [4:0] c, input int len,
                           input bit bad_par, input bit bad_stop);
        int nb, ones;
        logic p;
        nb = 5 + int'(c[1:0]);
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        p = c[4] ? (ones % 2 == 1) : (ones % 2 == 0);
        drive_bit(1'b0, len);
        for (int i = 0; i < nb; i++) drive_bit(d[i], len);
        if (c[3]) drive_bit(p ^ bad_par, len);
        drive_bit(!bad_stop, len);
        if (c[2]) drive_bit(1'b1, len);
        drive_bit(1'b1, 2 * len);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [9:0]  a5_exp;
        logic [7:0]  m_data;
        bit          m_valid, m_pe, m_fe, m_ovr, ok;
        int          cnt;

        reset_n = 0; psel = 0; penable = 0; pwrite = 0; pstrb = 0;
        paddr = 0; pwdata = 0; rx = 1; cts_n = 0;
        repeat (5) @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Reset state
        chk("rst_tx", tx, 1);
        chk("rst_rts_n", rts_n, 0);
        chk("rst_pready", pready, 1);
        chk("rst_prdata_idle", prdata, 0);
        chk("rst_pslverr", pslverr, 0);
        rd(12'h008, d); chk("rst_cfg", d, 32'h03);
        rd(12'h014, d); chk("rst_baud", d, 32'd26);
        rd(12'h010, d); chk("rst_stt", d, 0);
        rd(12'h00C, d); chk("rst_ctrl", d, 0);
        rd(12'h000, d); chk("rst_txdata", d, 0);
        rd(12'h004, d); chk("rst_rxdata", d, 0);
        mon_on = 1;

        // 0xA5 8N1 at 64 clocks per bit, pinned to a literal waveform
        a5_exp = 10'b1101001010;
        wr(12'h014, 3); wr(12'h008, 3); wr(12'h000, 32'hA5);
        txq.push_back(make_frame(8'hA5, 5'h03, 3));
        wr(12'h00C, 1);
        cnt = 0;
        while (tx !== 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("a5_start_seen", tx, 0);
        repeat (32) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("a5_bit", tx, a5_exp[i]);
            if (i == 4) begin
                rd(12'h010, d);
                chk("a5_busy_mid", d[0], 1);
                repeat (61) @(negedge clk);
            end else begin
                repeat (64) @(negedge clk);
            end
        end
        rd(12'h010, d); chk("a5_busy_after", d, 0);

        // CTS hold-off, then a mid-frame cts_n change that must not abort
        cts_n = 1;
        wr(12'h00C, 2); wr(12'h000, 32'h5A); wr(12'h00C, 3);
        repeat (200) @(negedge clk);
        chk("cts_hold_tx", tx, 1);
        rd(12'h010, d); chk("cts_hold_busy", d[0], 1);
        txq.push_back(make_frame(8'h5A, 5'h03, 3));
        @(negedge clk); cts_n = 0;
        cnt = 0;
        while (tx !== 1'b0 && cnt < 50) begin @(negedge clk); cnt++; end
        chk("cts_release_latency", (cnt <= 8), 1);
        repeat (100) @(negedge clk);
        cts_n = 1;
        wait_idle("cts_busy_clears");
        chk("cts_queue_drained", txq.size(), 0);
        wr(12'h00C, 0); cts_n = 0;

        // 0x3C 7E1 with a wrong parity bit
        wr(12'h008, 32'h1A);
        send_rx(8'h3C, 5'h1A, 64, 1, 0);
        rd(12'h010, d); chk("rx3c_stt", d, 32'h06);
        chk("rx3c_rts_n", rts_n, 1);
        wr(12'h010, 32'h04);
        rd(12'h010, d); chk("rx3c_w1c_parity", d, 32'h02);
        rd(12'h004, d); chk("rx3c_data", d, 32'h3C);
        repeat (3) @(negedge clk);
        chk("rx3c_rts_n_after_read", rts_n, 0);
        rd(12'h010, d); chk("rx3c_stt_after_read", d, 0);

        // False start: a short low glitch must not produce a byte
        wr(12'h008, 3);
        @(negedge clk); rx = 0; repeat (3) @(negedge clk); rx = 1;
        repeat (200) @(negedge clk);
        rd(12'h010, d); chk("false_start_stt", d, 0);

        // Two frames unread: first kept, overrun flagged
        send_rx(8'h11, 5'h03, 64, 0, 0);
        send_rx(8'h22, 5'h03, 64, 0, 0);
        rd(12'h010, d); chk("ovr_stt", d, 32'h12);
        rd(12'h004, d); chk("ovr_data_first_kept", d, 32'h11);
        repeat (3) @(negedge clk);
        chk("ovr_rts_n_after_read", rts_n, 0);
        wr(12'h010, 32'h10);
        rd(12'h010, d); chk("ovr_w1c", d, 0);

        // Erroneous accesses
        apb_rd(12'h018, d, e); chk("err_rd18_slverr", e, 1); chk("err_rd18_data", d, 0);
        apb_rd(12'h002, d, e); chk("err_rd02_slverr", e, 1); chk("err_rd02_data", d, 0);
        apb_rd(12'h108, d, e); chk("err_rd108_slverr", e, 1); chk("err_rd108_data", d, 0);
        apb_wr(12'h004, 32'hFF, 4'hF, e); chk("err_wr04_slverr", e, 1);
        rd(12'h004, d); chk("err_rxdata_unchanged", d, 32'h11);
        rd(12'h010, d); chk("err_stt_unchanged", d, 0);
        apb_rd(12'h008, d, e); chk("ok_rd_slverr", e, 0); chk("err_cfg_unchanged", d, 3);
        apb_wr(12'h014, 32'h1234, 4'h1, e);
        rd(12'h014, d); chk("baud_strobe_low_only", d, 32'h0034);

        // Random TX frames, with mid-frame CFG/BAUD writes and ignored restarts
        for (int it = 0; it < 12; it++) begin
            logic [7:0] td;
            logic [4:0] tc;
            int div;
            td = 8'($urandom);
            tc = 5'($urandom);
            div = $urandom_range(0, 2);
            wr(12'h014, div); wr(12'h008, tc); wr(12'h000, td);
            txq.push_back(make_frame(td, tc, div));
            wr(12'h00C, 1);
            if ($urandom_range(0, 1) == 1) begin
                wr(12'h008, $urandom);
                wr(12'h014, $urandom_range(0, 7));
                wr(12'h000, $urandom);
                wr(12'h00C, 1);
            end
            wait_idle("rand_tx_busy_clears");
            repeat (5) @(negedge clk);
            chk("rand_tx_queue_drained", txq.size(), 0);
        end

        // Random RX frames against a status model
        m_data = 8'h11; m_valid = 0; m_pe = 0; m_fe = 0; m_ovr = 0;
        for (int it = 0; it < 16; it++) begin
            logic [7:0] rd8;
            logic [4:0] rc;
            int div;
            bit bp, bs;
            int act;
            rd8 = 8'($urandom);
            rc = 5'($urandom);
            div = $urandom_range(0, 2);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            wr(12'h014, div); wr(12'h008, rc);
            send_rx(rd8, rc, 16 * (div + 1), bp, bs);
            if (!m_valid) begin
                m_data = rd8 & (8'hFF >> (3 - int'(rc[1:0])));
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            if (rc[3] && bp) m_pe = 1;
            if (bs) m_fe = 1;
            rd(12'h010, d);
            chk("rand_rx_stt", d, {27'd0, m_ovr, m_fe, m_pe, m_valid, 1'b0});
            chk("rand_rx_rts_n", rts_n, m_valid);
            act = $urandom_range(0, 3);
            if (act <= 1) begin
                rd(12'h004, d);
                chk("rand_rx_data", d, {24'd0, m_data});
                m_valid = 0;
            end else if (act == 2) begin
                logic [2:0] c3;
                c3 = 3'($urandom);
                wr(12'h010, {27'd0, c3, 2'b00});
                if (c3[0]) m_pe = 0;
                if (c3[1]) m_fe = 0;
                if (c3[2]) m_ovr = 0;
            end
            repeat (3) @(negedge clk);
            chk("rand_rx_rts_n_after", rts_n, m_valid);
            rd(12'h010, d);
            chk("rand_rx_stt_after", d, {27'd0, m_ovr, m_fe, m_pe, m_valid, 1'b0});
        end

        ok = (txq.size() == 0) && !in_frame;
        chk("final_tx_model_empty", ok, 1);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
